matmul_apb_slave: RTL and testbench

APB slave front end of the matrix-multiplier accelerator. It sits between the APB bus driven by the stimulus/CPU and the matmul compute core. It holds the operand A/B banks and the control register, issues the start pulse to the core, and serves read-back of the control/flags registers and of scratchpad result elements through a wait-stated read path.

---
 rtl/matmul_pkg.sv | 35 +++
 rtl/matmul_apb_slave_if.sv | 29 ++
 rtl/matmul_strb_reg.sv | 31 +++
 rtl/matmul_apb_slave.sv | 179 +++++++++++++++++
 tb/tb_matmul_apb_slave.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants for the matmul APB front end: register offsets, address
// fields, control-register bit positions and the read-path FSM states.
package matmul_pkg;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned ROW_LSB    = 5;
    localparam int unsigned COL_LSB    = 7;
    localparam int unsigned CTRL_WIDTH = 16;

    localparam logic [REG_W-1:0] REG_CTRL    = 5'd0;
    localparam logic [REG_W-1:0] REG_OPA     = 5'd4;
    localparam logic [REG_W-1:0] REG_OPB     = 5'd8;
    localparam logic [REG_W-1:0] REG_FLAGS   = 5'd12;
    localparam logic [REG_W-1:0] REG_SP_BASE = 5'd16;
    localparam logic [REG_W-1:0] REG_SP_MASK = 5'b10011;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_MODE_BIT  = 1;
    localparam int unsigned CTRL_TGT_LSB   = 2;
    localparam int unsigned CTRL_SRC_LSB   = 4;
    localparam int unsigned CTRL_N_LSB     = 8;
    localparam int unsigned CTRL_K_LSB     = 10;
    localparam int unsigned CTRL_M_LSB     = 12;

    localparam int unsigned FLAG_BUSY_BIT = 0;
    localparam int unsigned FLAG_DONE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SP_WAIT  = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

endpackage

// File: rtl/matmul_apb_slave_if.sv
// APB bus bundle between the CPU/stimulus master and the matmul front end.
interface matmul_apb_slave_if #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [BUS_WIDTH-1:0]  pwdata;
    logic [MAX_DIM-1:0]    pstrb;
    logic [BUS_WIDTH-1:0]  prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/matmul_strb_reg.sv
// Lane-masked register: each LANE_W slice is loaded only when its strobe is set.
module matmul_strb_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [WIDTH/LANE_W-1:0]   strb_i,
    input  logic [WIDTH-1:0]          wdata_i,
    output logic [WIDTH-1:0]          q_o
);
    localparam int unsigned LANES = WIDTH / LANE_W;

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            data_q <= '0;
        end else if (we_i) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (strb_i[k]) begin
                    data_q[k*LANE_W +: LANE_W] <= wdata_i[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/matmul_apb_slave.sv
// APB slave front end of the matmul accelerator: operand banks, control/flags
// registers, start pulse generation and wait-stated scratchpad read-back.
module matmul_apb_slave
    import matmul_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned SP_NTARGETS = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    matmul_apb_slave_if.slave                           apb,
    output logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)-1:0] a_mat_o,
    output logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)-1:0] b_mat_o,
    output logic [CTRL_WIDTH-1:0]                       ctrl_o,
    output logic                                        start_o,
    input  logic                                        busy_i,
    input  logic                                        done_i,
    output logic                                        sp_rd_o,
    output logic [IDX_W-1:0]                            sp_sel_o,
    output logic [IDX_W-1:0]                            sp_row_o,
    output logic [IDX_W-1:0]                            sp_col_o,
    input  logic [BUS_WIDTH-1:0]                        sp_rdata_i,
    input  logic                                        sp_rvalid_i
);
    localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned CTRL_LANES = CTRL_WIDTH / DATA_WIDTH;

    state_e               state_q;
    logic                 pready_q;
    logic                 pslverr_q;
    logic [BUS_WIDTH-1:0] prdata_q;
    logic                 start_q;
    logic                 sp_rd_q;
    logic [IDX_W-1:0]     sp_sel_q;
    logic [IDX_W-1:0]     sp_row_q;
    logic [IDX_W-1:0]     sp_col_q;
    logic                 done_flag_q;

    logic [REG_W-1:0]     reg_c;
    logic [IDX_W-1:0]     row_c;
    logic [IDX_W-1:0]     col_c;
    logic [IDX_W-1:0]     sp_idx_c;
    logic                 is_ctrl_c, is_opa_c, is_opb_c, is_flags_c, is_sp_c, sp_ok_c;
    logic                 take_c, wr_reg_c, wr_en_c, err_c, sp_go_c;
    logic                 start_c, done_clr_c;
    logic [BUS_WIDTH-1:0] rd_data_c;
    logic                 unused_addr;

    assign unused_addr = ^apb.paddr[ADDR_WIDTH-1:COL_LSB+IDX_W];

    // Address decode and per-access qualification, evaluated in the access cycle
    always_comb begin
        reg_c      = apb.paddr[REG_W-1:0];
        row_c      = apb.paddr[ROW_LSB +: IDX_W];
        col_c      = apb.paddr[COL_LSB +: IDX_W];
        sp_idx_c   = reg_c[3:2];
        is_ctrl_c  = (reg_c == REG_CTRL);
        is_opa_c   = (reg_c == REG_OPA);
        is_opb_c   = (reg_c == REG_OPB);
        is_flags_c = (reg_c == REG_FLAGS);
        is_sp_c    = ((reg_c & REG_SP_MASK) == REG_SP_BASE);
        sp_ok_c    = is_sp_c && (32'(sp_idx_c) < SP_NTARGETS);
        take_c     = apb.psel && apb.penable && (state_q == ST_IDLE);
        wr_reg_c   = apb.pwrite && (is_ctrl_c || is_opa_c || is_opb_c);
        wr_en_c    = take_c && wr_reg_c && !busy_i;
        err_c      = !(is_ctrl_c || is_opa_c || is_opb_c || is_flags_c || sp_ok_c)
                     || (wr_reg_c && busy_i);
        sp_go_c    = take_c && !apb.pwrite && sp_ok_c;
        // Only a strobed 1 in the start bit counts; a 0->1 edge launches the core
        done_clr_c = wr_en_c && is_ctrl_c && apb.pstrb[CTRL_START_BIT]
                     && apb.pwdata[CTRL_START_BIT];
        start_c    = done_clr_c && !ctrl_o[CTRL_START_BIT];
        rd_data_c  = '0;
        if (is_ctrl_c) begin
            rd_data_c = BUS_WIDTH'(ctrl_o);
        end else if (is_flags_c) begin
            rd_data_c[FLAG_BUSY_BIT] = busy_i;
            rd_data_c[FLAG_DONE_BIT] = done_flag_q;
        end
    end

    matmul_strb_reg #(.WIDTH(CTRL_WIDTH), .LANE_W(DATA_WIDTH)) u_ctrl (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_en_c && is_ctrl_c),
        .strb_i  (apb.pstrb[CTRL_LANES-1:0]),
        .wdata_i (apb.pwdata[CTRL_WIDTH-1:0]),
        .q_o     (ctrl_o)
    );

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_bank
        logic hit_c;
        assign hit_c = (row_c == IDX_W'(r));

        matmul_strb_reg #(.WIDTH(BUS_WIDTH), .LANE_W(DATA_WIDTH)) u_a_row (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (wr_en_c && is_opa_c && hit_c),
            .strb_i  (apb.pstrb),
            .wdata_i (apb.pwdata),
            .q_o     (a_mat_o[r*BUS_WIDTH +: BUS_WIDTH])
        );

        matmul_strb_reg #(.WIDTH(BUS_WIDTH), .LANE_W(DATA_WIDTH)) u_b_col (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (wr_en_c && is_opb_c && hit_c),
            .strb_i  (apb.pstrb),
            .wdata_i (apb.pwdata),
            .q_o     (b_mat_o[r*BUS_WIDTH +: BUS_WIDTH])
        );
    end

    // Transfer FSM: register accesses finish at once, scratchpad reads wait for rvalid
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q     <= ST_IDLE;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            start_q     <= 1'b0;
            sp_rd_q     <= 1'b0;
            sp_sel_q    <= '0;
            sp_row_q    <= '0;
            sp_col_q    <= '0;
            done_flag_q <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            start_q   <= 1'b0;
            sp_rd_q   <= 1'b0;
            if (done_i) begin
                done_flag_q <= 1'b1;
            end else if (done_clr_c) begin
                done_flag_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sp_go_c) begin
                        sp_rd_q  <= 1'b1;
                        sp_sel_q <= sp_idx_c;
                        sp_row_q <= row_c;
                        sp_col_q <= col_c;
                        state_q  <= ST_SP_WAIT;
                    end else if (take_c) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= err_c;
                        start_q   <= start_c;
                        if (!apb.pwrite) begin
                            prdata_q <= rd_data_c;
                        end
                        state_q <= ST_COMPLETE;
                    end
                end
                ST_SP_WAIT: begin
                    if (sp_rvalid_i) begin
                        prdata_q <= sp_rdata_i;
                        pready_q <= 1'b1;
                        state_q  <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign start_o     = start_q;
    assign sp_rd_o     = sp_rd_q;
    assign sp_sel_o    = sp_sel_q;
    assign sp_row_o    = sp_row_q;
    assign sp_col_o    = sp_col_q;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Bench for matmul_apb_slave: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural register-map model.
module tb_matmul_apb_slave;

    localparam int unsigned BW = 32;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned MD = BW / DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [BW*MD-1:0] a_mat, b_mat;
    logic [15:0]    ctrl;
    logic           start, sp_rd;
    logic           busy = 1'b0, done = 1'b0;
    logic [1:0]     sp_sel, sp_row, sp_col;
    logic [BW-1:0]  sp_rdata = '0;
    logic           sp_rvalid = 1'b0;

    matmul_apb_slave_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    matmul_apb_slave #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SP_NTARGETS(1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst),
        .apb         (apb),
        .a_mat_o     (a_mat),
        .b_mat_o     (b_mat),
        .ctrl_o      (ctrl),
        .start_o     (start),
        .busy_i      (busy),
        .done_i      (done),
        .sp_rd_o     (sp_rd),
        .sp_sel_o    (sp_sel),
        .sp_row_o    (sp_row),
        .sp_col_o    (sp_col),
        .sp_rdata_i  (sp_rdata),
        .sp_rvalid_i (sp_rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0, sprd_cnt = 0, pready_cnt = 0;
    int sp_lat = 1;
    logic [31:0] sp_resp = '0;

    // Reference state for the randomized phase
    logic [31:0] a_m [MD];
    logic [31:0] b_m [MD];
    logic [15:0] ctrl_m;
    logic        done_m;
    logic [31:0] prdata_m;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_wait;
        int          exp_sprd;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] rd;
    logic        err;
    int          w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (st[k]) m[8*k +: 8] = 8'hFF;
        return (old & ~m) | (wd & m);
    endfunction

    // Event monitors sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (start) start_cnt++;
        if (sp_rd) sprd_cnt++;
        if (apb.pready) pready_cnt++;
    end

    // Scratchpad responder: rvalid arrives sp_lat cycles after sp_rd_o
    initial forever begin
        @(negedge clk);
        if (sp_rd) begin
            repeat (sp_lat - 1) @(negedge clk);
            sp_rdata  = sp_resp;
            sp_rvalid = 1'b1;
            @(negedge clk);
            sp_rvalid = 1'b0;
            sp_rdata  = '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic dpulse,
                        output logic [31:0] rdo, output logic erro, output int waits);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
        apb.paddr = addr; apb.pwdata = wd; apb.pstrb = st;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        if (dpulse) done = 1'b1;
        waits = 0;
        forever begin
            @(posedge clk); #1;
            done = 1'b0;
            if (apb.pready) break;
            waits++;
            if (waits > 40) break;
        end
        rdo = apb.prdata; erro = apb.pslverr;
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(posedge clk); #1;
        chk("pready_one_cycle", 32'(apb.pready), 32'd0);
    endtask

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;

        vecs[0] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,        1'b0, 0, 0};
        vecs[1] = '{1'b0, 16'h000C, 32'h0,        4'h0, 32'h0,        1'b0, 0, 0};
        vecs[2] = '{1'b1, 16'h0024, 32'h04030201, 4'hF, 32'h0,        1'b0, 0, 0};
        vecs[3] = '{1'b1, 16'h0024, 32'hFFFFFFFF, 4'h5, 32'h0,        1'b0, 0, 0};
        vecs[4] = '{1'b0, 16'h0024, 32'h0,        4'h0, 32'h0,        1'b0, 0, 0};
        vecs[5] = '{1'b0, 16'h0003, 32'h0,        4'h0, 32'h0,        1'b1, 0, 0};
        vecs[6] = '{1'b0, 16'h0014, 32'h0,        4'h0, 32'h0,        1'b1, 0, 0};
        vecs[7] = '{1'b0, 16'h01D0, 32'h0,        4'h0, 32'h12345678, 1'b0, 3, 1};
        vecs[8] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,        1'b0, 0, 0};
        vecs[9] = '{1'b1, 16'h0048, 32'hA1B2C3D4, 4'hA, 32'h0,        1'b0, 0, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_pready", 32'(apb.pready), 0);
        chk("rst_pslverr", 32'(apb.pslverr), 0);
        chk("rst_prdata", apb.prdata, 0);
        chk("rst_ctrl", 32'(ctrl), 0);
        chk("rst_start_sprd", 32'({start, sp_rd}), 0);

        // Directed vector table
        sp_resp = 32'h12345678; sp_lat = 3;
        for (int i = 0; i < 10; i++) begin
            int s0;
            s0 = sprd_cnt;
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st, 1'b0, rd, err, w);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_wait", i), 32'(w), 32'(vecs[i].exp_wait));
            chk($sformatf("vec%0d_sprd", i), 32'(sprd_cnt - s0), 32'(vecs[i].exp_sprd));
        end
        chk("a_row1", a_mat[32 +: 32], 32'h04FF02FF);
        chk("b_col2", b_mat[64 +: 32], 32'hA100C300);
        chk("sp_coord", 32'({sp_sel, sp_row, sp_col}), 32'({2'd0, 2'd2, 2'd3}));

        // Start pulse and rewrite without pulse
        begin
            int s0;
            s0 = start_cnt;
            xfer(1'b1, 16'h0000, 32'h00000F0D, 4'h3, 1'b0, rd, err, w);
            chk("start_pulse", 32'(start_cnt - s0), 1);
            chk("ctrl_val", 32'(ctrl), 32'h0F0D);
            s0 = start_cnt;
            xfer(1'b1, 16'h0000, 32'h00000F0D, 4'h3, 1'b0, rd, err, w);
            chk("start_rewrite", 32'(start_cnt - s0), 0);
        end

        // Writes rejected while busy, done captured
        busy = 1'b1;
        xfer(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b0, rd, err, w);
        chk("busy_wr_err", 32'(err), 1);
        chk("busy_a_row0", a_mat[0 +: 32], 32'h0);
        xfer(1'b1, 16'h0000, 32'h0, 4'h3, 1'b0, rd, err, w);
        chk("busy_ctrl_err", 32'(err), 1);
        chk("busy_ctrl_val", 32'(ctrl), 32'h0F0D);
        xfer(1'b0, 16'h000C, 32'h0, 4'h0, 1'b1, rd, err, w);
        chk("flags_busy", rd, 32'h1);
        busy = 1'b0;
        xfer(1'b0, 16'h000C, 32'h0, 4'h0, 1'b0, rd, err, w);
        chk("flags_done", rd, 32'h2);

        // done_i beats a simultaneous clear; a plain start clears done
        begin
            int s0;
            xfer(1'b1, 16'h0000, 32'h00000F0C, 4'h3, 1'b0, rd, err, w);
            s0 = start_cnt;
            xfer(1'b1, 16'h0000, 32'h00000F0D, 4'h3, 1'b1, rd, err, w);
            chk("restart_pulse", 32'(start_cnt - s0), 1);
            xfer(1'b0, 16'h000C, 32'h0, 4'h0, 1'b0, rd, err, w);
            chk("done_wins", rd, 32'h2);
            xfer(1'b1, 16'h0000, 32'h00000F0C, 4'h3, 1'b0, rd, err, w);
            xfer(1'b1, 16'h0000, 32'h00000F0D, 4'h3, 1'b0, rd, err, w);
            xfer(1'b0, 16'h000C, 32'h0, 4'h0, 1'b0, rd, err, w);
            chk("done_cleared", rd, 32'h0);
        end

        // Back-to-back reads with penable held high
        busy = 1'b1;
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 16'h0000;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        chk("b2b_first_ready", 32'(apb.pready), 1);
        chk("b2b_first_data", apb.prdata, 32'h0F0D);
        apb.paddr = 16'h000C;
        @(posedge clk); #1;
        chk("b2b_gap", 32'(apb.pready), 0);
        @(posedge clk); #1;
        chk("b2b_second_ready", 32'(apb.pready), 1);
        chk("b2b_second_data", apb.prdata, 32'h1);
        apb.psel = 1'b0; apb.penable = 1'b0; busy = 1'b0;
        @(posedge clk); #1;

        // Reset while waiting on the scratchpad; late rvalid must be ignored
        begin
            int s0, p0;
            sp_lat = 6; sp_resp = 32'hCAFEF00D;
            s0 = sprd_cnt;
            apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = 16'h0010;
            @(posedge clk); #1;
            apb.penable = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("spw_no_ready", 32'(apb.pready), 0);
            p0 = pready_cnt;
            rst = 1'b1;
            #1;
            chk("spw_rst_ctrl", 32'(ctrl), 0);
            apb.psel = 1'b0; apb.penable = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("spw_sprd", 32'(sprd_cnt - s0), 1);
            chk("spw_late_ready", 32'(pready_cnt - p0), 0);
            chk("spw_prdata", apb.prdata, 32'h0);
            xfer(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, rd, err, w);
            chk("spw_after_wait", 32'(w), 0);
        end

        // Randomized phase against the register-map model
        for (int r = 0; r < MD; r++) begin a_m[r] = '0; b_m[r] = '0; end
        ctrl_m = '0; done_m = 1'b0; prdata_m = '0;
        for (int n = 0; n < 250; n++) begin
            logic [4:0]  rg;
            logic [1:0]  row, col;
            logic        wr, dp, e_err, clr;
            logic [31:0] wd;
            logic [3:0]  st;
            logic [15:0] addr;
            int          sel, e_wait, e_start, e_sprd, s0, q0;
            sel = $urandom_range(0, 8);
            rg = (sel == 8) ? 5'($urandom_range(0, 7) * 4 + $urandom_range(1, 3)) : 5'(sel * 4);
            row = 2'($urandom_range(0, 3)); col = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1)); wd = $urandom; st = 4'($urandom_range(0, 15));
            dp = ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 3) == 0);
            sp_lat = $urandom_range(1, 4); sp_resp = $urandom;
            addr = {7'($urandom_range(0, 127)), col, row, rg};

            e_err = 1'b0; e_wait = 0; e_start = 0; e_sprd = 0; clr = 1'b0;
            case (rg)
                5'd0: if (wr) begin
                    if (busy) e_err = 1'b1;
                    else begin
                        clr = st[0] && wd[0];
                        e_start = (clr && !ctrl_m[0]) ? 1 : 0;
                        ctrl_m = merge({16'h0, ctrl_m}, wd, {2'b00, st[1:0]}) & 32'hFFFF;
                    end
                end else prdata_m = {16'h0, ctrl_m};
                5'd4: if (wr) begin
                    if (busy) e_err = 1'b1; else a_m[row] = merge(a_m[row], wd, st);
                end else prdata_m = '0;
                5'd8: if (wr) begin
                    if (busy) e_err = 1'b1; else b_m[row] = merge(b_m[row], wd, st);
                end else prdata_m = '0;
                5'd12: if (!wr) prdata_m = {30'h0, done_m, busy};
                5'd16: if (!wr) begin prdata_m = sp_resp; e_sprd = 1; e_wait = sp_lat; end
                default: begin e_err = 1'b1; if (!wr) prdata_m = '0; end
            endcase
            if (dp) done_m = 1'b1; else if (clr) done_m = 1'b0;

            s0 = start_cnt; q0 = sprd_cnt;
            xfer(wr, addr, wd, st, dp, rd, err, w);
            chk($sformatf("rnd%0d_rdata", n), rd, prdata_m);
            chk($sformatf("rnd%0d_err", n), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d_wait", n), 32'(w), 32'(e_wait));
            chk($sformatf("rnd%0d_start", n), 32'(start_cnt - s0), 32'(e_start));
            chk($sformatf("rnd%0d_sprd", n), 32'(sprd_cnt - q0), 32'(e_sprd));
            chk($sformatf("rnd%0d_ctrl", n), 32'(ctrl), 32'(ctrl_m));
            chk($sformatf("rnd%0d_a", n), a_mat[32*int'(row) +: 32], a_m[row]);
            chk($sformatf("rnd%0d_b", n), b_mat[32*int'(row) +: 32], b_m[row]);
            if (e_sprd == 1) chk($sformatf("rnd%0d_spxy", n), 32'({sp_sel, sp_row, sp_col}),
                                 32'({2'd0, row, col}));
        end
        busy = 1'b0;
        for (int r = 0; r < MD; r++) begin
            chk($sformatf("final_a%0d", r), a_mat[32*r +: 32], a_m[r]);
            chk($sformatf("final_b%0d", r), b_mat[32*r +: 32], b_m[r]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
